// File: rtl/neopixel_strip_driver.sv
// -----------------------------------------------------------------------------
// neopixel_strip_driver
//   WS2812-class strip driver. Holds up to NUM_PIXELS colour words in a local
//   buffer and serialises the first len_q of them (pixel 0 first, MSB first)
//   onto one data line, followed by a low latch gap. Optional free-running
//   refresh restarts the frame directly out of the latch gap.
//
// Ports
//   CLOCK_50    in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   wr_en       in   pixel buffer write strobe (honoured only while ready)
//   wr_addr     in   pixel index to write (>= NUM_PIXELS ignored)
//   wr_data     in   colour word to write
//   len         in   pixels per frame, sampled on accepted go (0 or too big = all)
//   go          in   start a frame (honoured only while ready)
//   repeat_en   in   refresh continuously; sampled in the last latch cycle
//   ready       out  idle, go and writes are accepted
//   frame_done  out  one-cycle pulse after the final latch cycle
//   neo_out     out  serial data line
// -----------------------------------------------------------------------------
module neopixel_strip_driver #(
    parameter int NUM_PIXELS = 8,
    parameter int COLOR_BITS = 24,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int T_BIT      = 63,
    parameter int T_LATCH    = 3000,
    parameter int AW         = $clog2(NUM_PIXELS)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [COLOR_BITS-1:0] wr_data,
    input  logic [AW:0]           len,
    input  logic                  go,
    input  logic                  repeat_en,
    output logic                  ready,
    output logic                  frame_done,
    output logic                  neo_out
);

    localparam int TMAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int MSB  = COLOR_BITS - 1;

    // Timer reload values are "duration - 1": the timer counts down to 0 and
    // the phase ends on the cycle it reads 0.
    localparam logic [TW-1:0] T0H_M1  = TW'(T0H - 1);
    localparam logic [TW-1:0] T1H_M1  = TW'(T1H - 1);
    localparam logic [TW-1:0] T0L_M1  = TW'(T_BIT - T0H - 1);
    localparam logic [TW-1:0] T1L_M1  = TW'(T_BIT - T1H - 1);
    localparam logic [TW-1:0] TLAT_M1 = TW'(T_LATCH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(COLOR_BITS - 1);
    localparam logic [AW:0]   NP_LEN   = (AW + 1)'(NUM_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [BW-1:0]         bit_q;
    logic [AW-1:0]         pix_q;
    logic [AW:0]           len_q;
    logic [COLOR_BITS-1:0] shift_q;
    logic                  ready_q;
    logic                  frame_done_q;
    logic                  neo_q;

    // Pixel buffer: deliberately not reset.
    logic [COLOR_BITS-1:0] mem_q [NUM_PIXELS];

    logic                  addr_ok;
    logic                  wr_accept;
    logic [COLOR_BITS-1:0] pix0_d;
    logic [AW-1:0]         pix_nxt_d;
    logic [COLOR_BITS-1:0] shift_d;
    logic [AW:0]           len_d;
    logic                  last_bit_d;

    // With a power-of-two depth every address is in range.
    generate
        if ((1 << AW) == NUM_PIXELS) begin : g_addr_pow2
            assign addr_ok = 1'b1;
        end else begin : g_addr_npow2
            assign addr_ok = (wr_addr < AW'(NUM_PIXELS));
        end
    endgenerate

    assign wr_accept = ready_q & wr_en & addr_ok;

    always_ff @(posedge CLOCK_50) begin
        if (wr_accept) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A write to pixel 0 in the same cycle as go must be what gets sent, so
    // bypass the buffer for the first load.
    assign pix0_d    = (wr_accept && (wr_addr == '0)) ? wr_data : mem_q[0];
    assign pix_nxt_d = pix_q + 1'b1;
    // Next shift-register contents: reload at a pixel boundary, else shift.
    assign shift_d   = (bit_q == LAST_BIT) ? mem_q[pix_nxt_d]
                                           : {shift_q[MSB-1:0], 1'b0};
    assign len_d     = ((len == '0) || (len > NP_LEN)) ? NP_LEN : len;
    assign last_bit_d = (bit_q == LAST_BIT) && ({1'b0, pix_q} == (len_q - 1'b1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            pix_q        <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            neo_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        len_q   <= len_d;
                        shift_q <= pix0_d;
                        bit_q   <= '0;
                        pix_q   <= '0;
                        timer_q <= pix0_d[MSB] ? T1H_M1 : T0H_M1;
                        neo_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (timer_q == '0) begin
                        timer_q <= shift_q[MSB] ? T1L_M1 : T0L_M1;
                        neo_q   <= 1'b0;
                        state_q <= S_LOW;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_LOW: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (last_bit_d) begin
                        timer_q <= TLAT_M1;
                        state_q <= S_LATCH;
                    end else begin
                        shift_q <= shift_d;
                        if (bit_q == LAST_BIT) begin
                            bit_q <= '0;
                            pix_q <= pix_nxt_d;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                        timer_q <= shift_d[MSB] ? T1H_M1 : T0H_M1;
                        neo_q   <= 1'b1;
                        state_q <= S_HIGH;
                    end
                end
                S_LATCH: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        frame_done_q <= 1'b1;
                        bit_q        <= '0;
                        pix_q        <= '0;
                        if (repeat_en) begin
                            // Restart straight from the latch gap; len_q kept.
                            shift_q <= pix0_d;
                            timer_q <= pix0_d[MSB] ? T1H_M1 : T0H_M1;
                            neo_q   <= 1'b1;
                            state_q <= S_HIGH;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    neo_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign frame_done = frame_done_q;
    assign neo_out    = neo_q;

endmodule

// File: tb/tb_neopixel_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_neopixel_strip_driver
//   Stimulus pushes the expected pulse stream of each frame (one entry per bit
//   holding the required high width, then a frame-end entry) into a queue,
//   derived from a plain array copy of the pixel buffer. A separate monitor
//   measures neo_out pulses and frame_done and pops/compares.
// -----------------------------------------------------------------------------
module tb_neopixel_strip_driver;

    localparam int NP      = 4;
    localparam int CB      = 24;
    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int T_BIT   = 63;
    localparam int T_LATCH = 3000;
    localparam int AW      = $clog2(NP);
    localparam int BUDGET  = NP * CB * T_BIT + T_LATCH + 200;

    logic          CLOCK_50  = 1'b0;
    logic          reset_n   = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [CB-1:0] wr_data   = '0;
    logic [AW:0]   len       = '0;
    logic          go        = 1'b0;
    logic          repeat_en = 1'b0;
    logic          ready;
    logic          frame_done;
    logic          neo_out;

    neopixel_strip_driver #(
        .NUM_PIXELS(NP), .COLOR_BITS(CB), .T0H(T0H), .T1H(T1H),
        .T_BIT(T_BIT), .T_LATCH(T_LATCH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .go        (go),
        .repeat_en (repeat_en),
        .ready     (ready),
        .frame_done(frame_done),
        .neo_out   (neo_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        bit done;
        int width;
    } exp_t;

    exp_t          expq[$];
    logic [CB-1:0] model_buf [NP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input int l);
        return (l == 0 || l > NP) ? NP : l;
    endfunction

    // Expected frame: each pixel MSB first, high width set by the bit value.
    task automatic push_frame(input int l);
        exp_t e;
        for (int p = 0; p < eff_len(l); p++) begin
            for (int b = CB - 1; b >= 0; b--) begin
                e.done  = 1'b0;
                e.width = model_buf[p][b] ? T1H : T0H;
                expq.push_back(e);
            end
        end
        e.done  = 1'b1;
        e.width = 0;
        expq.push_back(e);
    endtask

    // Monitor: pulse widths, low gaps, latch gap and frame ends.
    initial begin : monitor
        int   hi_cnt;
        int   lo_cnt;
        int   last_w;
        bit   prev_neo;
        bit   in_frame;
        exp_t e;
        hi_cnt = 0; lo_cnt = 0; last_w = 0; prev_neo = 0; in_frame = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!reset_n) begin
                hi_cnt = 0; lo_cnt = 0; prev_neo = 0; in_frame = 0;
            end else begin
                if (frame_done === 1'b1) begin
                    done_cnt++;
                    chk("done_expected", expq.size() != 0, 1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("done_order", e.done, 1);
                        chk("latch_low_cycles", lo_cnt, T_BIT - last_w + T_LATCH);
                    end
                    in_frame = 0;
                end
                if (neo_out === 1'b1) begin
                    if (!prev_neo) begin
                        if (in_frame) chk("bit_low_cycles", lo_cnt, T_BIT - last_w);
                        in_frame = 1;
                        hi_cnt   = 0;
                    end
                    hi_cnt++;
                end else begin
                    if (prev_neo) begin
                        chk("bit_expected", expq.size() != 0, 1);
                        if (expq.size() != 0) begin
                            e = expq.pop_front();
                            chk("bit_kind", e.done, 0);
                            chk("bit_high_cycles", hi_cnt, e.width);
                        end
                        last_w = hi_cnt;
                        lo_cnt = 0;
                    end
                    lo_cnt++;
                end
                prev_neo = (neo_out === 1'b1);
            end
        end
    end

    // All stimulus tasks enter and leave on a falling edge.
    task automatic write_px(input int a, input logic [CB-1:0] d, input bit taken);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge CLOCK_50);
        wr_en = 1'b0;
        if (taken) model_buf[a] = d;
    endtask

    task automatic start(input int l, input bit with_wr, input logic [CB-1:0] d, output int g);
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = d;
            model_buf[0] = d;
        end
        go  = 1'b1;
        len = (AW + 1)'(l);
        push_frame(l);
        @(negedge CLOCK_50);
        go    = 1'b0;
        wr_en = 1'b0;
        g     = cyc;
        chk("go_neo_rise", neo_out, 1);
        chk("go_ready_low", ready, 0);
    endtask

    task automatic wait_done(input bit exp_ready, output int d);
        int n;
        n = 0;
        d = cyc;
        while (frame_done !== 1'b1 && n < BUDGET) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("frame_done_within_budget", frame_done === 1'b1, 1);
        if (frame_done === 1'b1) chk("ready_at_done", ready, exp_ready);
        d = cyc;
    endtask

    initial begin : stim
        int g;
        int d;
        int n;
        int dc;
        int l;
        int rises;
        logic [CB-1:0] r;

        // Reset / idle
        repeat (3) @(negedge CLOCK_50);
        chk("reset_ready", ready, 1);
        chk("reset_neo", neo_out, 0);
        chk("reset_done", frame_done, 0);
        reset_n = 1'b1;
        rises = 0;
        repeat (100) begin
            @(negedge CLOCK_50);
            if (neo_out !== 1'b0) rises++;
        end
        chk("idle_quiet", rises, 0);
        chk("idle_ready", ready, 1);

        // Single pixel A50000
        write_px(0, 24'hA50000, 1);
        start(1, 0, '0, g);
        wait_done(1, d);
        chk("single_total", d - g, CB * T_BIT + T_LATCH);

        // Full frame, len=0 selects all pixels
        write_px(0, 24'hFFFFFF, 1);
        write_px(1, 24'h000000, 1);
        write_px(2, 24'hFFFFFF, 1);
        write_px(3, 24'h000000, 1);
        start(0, 0, '0, g);
        wait_done(1, d);
        chk("full_total", d - g, NP * CB * T_BIT + T_LATCH);

        // Write while busy is dropped; next go in the frame_done cycle
        repeat (5) @(negedge CLOCK_50);
        start(1, 0, '0, g);
        repeat (500) @(negedge CLOCK_50);
        write_px(0, 24'h000000, 0);
        wait_done(1, d);
        start(1, 0, '0, g);
        wait_done(1, d);
        chk("b2b_total", d - g, CB * T_BIT + T_LATCH);

        // Repeat mode, len=2
        repeat (5) @(negedge CLOCK_50);
        write_px(0, CB'($urandom()), 1);
        write_px(1, CB'($urandom()), 1);
        repeat_en = 1'b1;
        start(2, 0, '0, g);
        wait_done(0, d);
        chk("rep1_total", d - g, 2 * CB * T_BIT + T_LATCH);
        chk("rep1_neo_at_done", neo_out, 1);
        push_frame(2);
        g = d;
        repeat (300) @(negedge CLOCK_50);
        go  = 1'b1;             // ignored: busy, must not alter len_q
        len = 3'd1;
        @(negedge CLOCK_50);
        go = 1'b0;
        wait_done(0, d);
        chk("rep2_period", d - g, 2 * CB * T_BIT + T_LATCH);
        push_frame(2);
        g = d;
        repeat (1000) @(negedge CLOCK_50);
        repeat_en = 1'b0;
        wait_done(1, d);
        chk("rep3_period", d - g, 2 * CB * T_BIT + T_LATCH);
        dc = done_cnt;
        repeat (200) @(negedge CLOCK_50);
        chk("rep_no_extra_done", done_cnt, dc);
        chk("rep_ready_after", ready, 1);

        // Reset while neo_out is high
        write_px(0, CB'($urandom()) | 24'h800000, 1);
        start(1, 0, '0, g);
        repeat (100) @(negedge CLOCK_50);
        n = 0;
        while (neo_out !== 1'b1 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("found_high_phase", neo_out, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_neo_immediate", neo_out, 0);
        chk("rst_ready", ready, 1);
        chk("rst_no_done", frame_done, 0);
        expq.delete();
        dc = done_cnt;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("rst_no_done_count", done_cnt, dc);
        // Restart with a write/go collision: new px0 must be sent
        r = CB'($urandom());
        start(1, 1, r, g);
        wait_done(1, d);
        chk("collision_total", d - g, CB * T_BIT + T_LATCH);

        // Randomised frames
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(negedge CLOCK_50);
            for (int p = 0; p < NP; p++) write_px(p, CB'($urandom()), 1);
            l = $urandom_range(0, 7);
            start(l, 0, '0, g);
            wait_done(1, d);
            chk("rand_total", d - g, eff_len(l) * CB * T_BIT + T_LATCH);
        end

        repeat (10) @(negedge CLOCK_50);
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
